game_round_scheduler: RTL and testbench

//  Sequences the game master FSM across a multi-round game: gates master via game_enable,

---
 rtl/game_round_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_game_round_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_scheduler.sv
// Round scheduler beside the game master: gates it, times the end-of-round pause,
// judges each round and keeps score/lives/level. Optional high-score register: GAME_HIGH_SCORE_EN.
module game_round_scheduler #(
    parameter int TIMER_CYCLES   = 25_000_000,
    parameter int SCORE_W        = 8,
    parameter int LIVES          = 3,
    parameter int LEVEL_W        = 3,
    parameter int HITS_PER_LEVEL = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               key,
    input  logic               round_end,
    input  logic               game_won,
    output logic               game_enable,
    output logic               end_of_game_timer_running,
    output logic               round_won,
    output logic               round_lost,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives,
    output logic [LEVEL_W-1:0] level,
`ifdef GAME_HIGH_SCORE_EN
    output logic               game_over,
    output logic [SCORE_W-1:0] high_score
`else
    output logic               game_over
`endif
);

    localparam int TW = $clog2(TIMER_CYCLES);
    localparam int HW = $clog2(HITS_PER_LEVEL + 1);

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;

    state_t             state_reg, state_next;
    logic               key_q_reg;
    logic               game_enable_reg, game_enable_next;
    logic               timer_running_reg, timer_running_next;
    logic [TW-1:0]      timer_reg, timer_next;
    logic               round_won_reg, round_won_next;
    logic               round_lost_reg, round_lost_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [3:0]         lives_reg, lives_next;
    logic [LEVEL_W-1:0] level_reg, level_next;
    logic [HW-1:0]      hit_cnt_reg, hit_cnt_next;
    logic [HW-1:0]      hit_inc;
    logic               game_over_reg, game_over_next;
`ifdef GAME_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_reg, high_score_next;
`endif

    logic key_rise;
    assign key_rise = key & ~key_q_reg;
    assign hit_inc  = hit_cnt_reg + HW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            key_q_reg         <= 1'b0;
            game_enable_reg   <= 1'b0;
            timer_running_reg <= 1'b0;
            timer_reg         <= '0;
            round_won_reg     <= 1'b0;
            round_lost_reg    <= 1'b0;
            score_reg         <= '0;
            lives_reg         <= 4'(LIVES);
            level_reg         <= '0;
            hit_cnt_reg       <= '0;
            game_over_reg     <= 1'b0;
`ifdef GAME_HIGH_SCORE_EN
            high_score_reg    <= '0;
`endif
        end else begin
            state_reg         <= state_next;
            key_q_reg         <= key;
            game_enable_reg   <= game_enable_next;
            timer_running_reg <= timer_running_next;
            timer_reg         <= timer_next;
            round_won_reg     <= round_won_next;
            round_lost_reg    <= round_lost_next;
            score_reg         <= score_next;
            lives_reg         <= lives_next;
            level_reg         <= level_next;
            hit_cnt_reg       <= hit_cnt_next;
            game_over_reg     <= game_over_next;
`ifdef GAME_HIGH_SCORE_EN
            high_score_reg    <= high_score_next;
`endif
        end
    end

    always_comb begin
        state_next         = state_reg;
        game_enable_next   = game_enable_reg;
        timer_running_next = timer_running_reg;
        timer_next         = timer_reg;
        round_won_next     = 1'b0;
        round_lost_next    = 1'b0;
        score_next         = score_reg;
        lives_next         = lives_reg;
        level_next         = level_reg;
        hit_cnt_next       = hit_cnt_reg;
        game_over_next     = game_over_reg;
`ifdef GAME_HIGH_SCORE_EN
        high_score_next    = high_score_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (key_rise) begin
                    state_next       = PLAY;
                    game_enable_next = 1'b1;
                end
            end
            PLAY: begin
                if (round_end) begin
                    state_next         = PAUSE;
                    timer_next         = TW'(TIMER_CYCLES - 1);
                    timer_running_next = 1'b1;
                end
            end
            PAUSE: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - TW'(1);
                end else begin
                    // game_won is sampled only now: the master may raise it late in the pause
                    timer_running_next = 1'b0;
                    if (game_won) begin
                        round_won_next = 1'b1;
                        state_next     = PLAY;
                        if (score_reg != {SCORE_W{1'b1}})
                            score_next = score_reg + SCORE_W'(1);
                        if (hit_inc == HW'(HITS_PER_LEVEL)) begin
                            hit_cnt_next = '0;
                            if (level_reg != {LEVEL_W{1'b1}})
                                level_next = level_reg + LEVEL_W'(1);
                        end else begin
                            hit_cnt_next = hit_inc;
                        end
                    end else begin
                        round_lost_next = 1'b1;
                        lives_next      = lives_reg - 4'd1;
                        if (lives_reg == 4'd1) begin
                            state_next       = OVER;
                            game_enable_next = 1'b0;
                            game_over_next   = 1'b1;
`ifdef GAME_HIGH_SCORE_EN
                            if (score_reg > high_score_reg)
                                high_score_next = score_reg;
`endif
                        end else begin
                            state_next = PLAY;
                        end
                    end
                end
            end
            OVER: begin
                if (key_rise) begin
                    state_next     = IDLE;
                    game_over_next = 1'b0;
                    score_next     = '0;
                    lives_next     = 4'(LIVES);
                    level_next     = '0;
                    hit_cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign game_enable               = game_enable_reg;
    assign end_of_game_timer_running = timer_running_reg;
    assign round_won                 = round_won_reg;
    assign round_lost                = round_lost_reg;
    assign score                     = score_reg;
    assign lives                     = lives_reg;
    assign level                     = level_reg;
    assign game_over                 = game_over_reg;
`ifdef GAME_HIGH_SCORE_EN
    assign high_score                = high_score_reg;
`endif

endmodule

// File: tb/tb_game_round_scheduler.sv
// Directed bench for game_round_scheduler: a table of rounds for one full game plus
// hand-written sequences for reset, key-edge, ignored round_end and mid-pause reset.
module tb_game_round_scheduler;

    localparam int TC = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key = 1'b0;
    logic       round_end = 1'b0;
    logic       game_won = 1'b0;
    logic       game_enable;
    logic       timer_running;
    logic       round_won;
    logic       round_lost;
    logic [7:0] score;
    logic [3:0] lives;
    logic [1:0] level;
    logic       game_over;
`ifdef GAME_HIGH_SCORE_EN
    logic [7:0] high_score;
`endif

    int total = 0;
    int bad = 0;

    game_round_scheduler #(
        .TIMER_CYCLES(TC), .SCORE_W(8), .LIVES(3), .LEVEL_W(2), .HITS_PER_LEVEL(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key(key),
        .round_end(round_end),
        .game_won(game_won),
        .game_enable(game_enable),
        .end_of_game_timer_running(timer_running),
        .round_won(round_won),
        .round_lost(round_lost),
        .score(score),
        .lives(lives),
        .level(level),
`ifdef GAME_HIGH_SCORE_EN
        .game_over(game_over),
        .high_score(high_score)
`else
        .game_over(game_over)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic won;
        logic hold_key;
        int   score;
        int   lives;
        int   level;
        logic over;
    } round_vec_t;

    round_vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_values(input string tag);
        check({tag, " game_enable"}, int'(game_enable), 0);
        check({tag, " timer_running"}, int'(timer_running), 0);
        check({tag, " round_won"}, int'(round_won), 0);
        check({tag, " round_lost"}, int'(round_lost), 0);
        check({tag, " score"}, int'(score), 0);
        check({tag, " lives"}, int'(lives), 3);
        check({tag, " level"}, int'(level), 0);
        check({tag, " game_over"}, int'(game_over), 0);
    endtask

    task automatic start_game();
        key = 1'b1;
        step();
        check("start game_enable", int'(game_enable), 1);
        key = 1'b0;
        step();
    endtask

    task automatic leave_over();
        key = 1'b0;
        step();
        key = 1'b1;
        step();
        key = 1'b0;
        check_idle_values("over->idle");
    endtask

    // Entered in PLAY right after a posedge (cycle T); returns at T+TC+2.
    task automatic play_round(input logic won, input logic hold_key, input int escore,
                              input int elives, input int elevel, input logic eover);
        round_end = 1'b1;
        game_won  = 1'b0;
        key       = hold_key;
        step();
        round_end = 1'b0;
        for (int c = 1; c <= TC; c++) begin
            check("pause timer_running", int'(timer_running), 1);
            check("pause no pulse", int'(round_won | round_lost), 0);
            check("pause game_enable", int'(game_enable), 1);
            if (c == 3) game_won = won;
            step();
        end
        check("judge timer_running", int'(timer_running), 0);
        check("judge round_won", int'(round_won), int'(won));
        check("judge round_lost", int'(round_lost), int'(!won));
        check("judge score", int'(score), escore);
        check("judge lives", int'(lives), elives);
        check("judge level", int'(level), elevel);
        check("judge game_over", int'(game_over), int'(eover));
        check("judge game_enable", int'(game_enable), int'(!eover));
        $display("round won=%0d score=%0d lives=%0d level=%0d over=%0d",
                 won, score, lives, level, game_over);
        game_won = 1'b0;
        step();
        check("pulse one cycle", int'(round_won | round_lost), 0);
    endtask

`ifdef GAME_HIGH_SCORE_EN
    // Plays nwins wins then losses until game over, predicting values with a small model.
    task automatic play_game(input int nwins);
        int s = 0, l = 3, lv = 0, h = 0;
        start_game();
        for (int i = 0; i < nwins; i++) begin
            s++;
            h++;
            if (h == 2) begin
                h = 0;
                if (lv < 3) lv++;
            end
            play_round(1'b1, 1'b0, s, l, lv, 1'b0);
        end
        while (l > 0) begin
            l--;
            play_round(1'b0, 1'b0, s, l, lv, l == 0);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i].won      = 1'b1;
            vecs[i].hold_key = 1'b0;
            vecs[i].score    = i + 1;
            vecs[i].lives    = 3;
            vecs[i].over     = 1'b0;
        end
        vecs[0].level = 0; vecs[1].level = 1; vecs[2].level = 1; vecs[3].level = 2;
        vecs[4].level = 2; vecs[5].level = 3; vecs[6].level = 3; vecs[7].level = 3;
        for (int i = 8; i < 11; i++) begin
            vecs[i].won      = 1'b0;
            vecs[i].hold_key = (i == 10);
            vecs[i].score    = 8;
            vecs[i].lives    = 10 - i;
            vecs[i].level    = 3;
            vecs[i].over     = (i == 10);
        end

        // Reset and idle with no key
        repeat (3) step();
        check_idle_values("in reset");
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            check_idle_values("idle hold");
        end

        // One full game from the table
        start_game();
        for (int i = 0; i < 11; i++)
            play_round(vecs[i].won, vecs[i].hold_key, vecs[i].score, vecs[i].lives,
                       vecs[i].level, vecs[i].over);

        // Key still held in OVER; round_end here must be ignored
        round_end = 1'b1;
        step();
        round_end = 1'b0;
        for (int i = 0; i < TC + 2; i++) begin
            check("over timer_running", int'(timer_running), 0);
            check("over game_over", int'(game_over), 1);
            check("over game_enable", int'(game_enable), 0);
            check("over score frozen", int'(score), 8);
            check("over level frozen", int'(level), 3);
            check("over no pulse", int'(round_won | round_lost), 0);
            step();
        end

        // Release and press: back to IDLE; holding the key does not start
        leave_over();
        key = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle key held game_enable", int'(game_enable), 0);
        end
        key = 1'b0;

        // round_end in IDLE ignored
        round_end = 1'b1;
        step();
        round_end = 1'b0;
        for (int i = 0; i < TC + 2; i++) begin
            check_idle_values("idle round_end");
            step();
        end

        // Reset in the middle of a pause
        start_game();
        play_round(1'b1, 1'b0, 1, 3, 0, 1'b0);
        round_end = 1'b1;
        step();
        round_end = 1'b0;
        game_won  = 1'b1;
        repeat (3) step();
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_values("mid-pause reset");
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_values("held reset");
        end
        reset_n = 1'b1;
        for (int i = 0; i < TC + 2; i++) begin
            step();
            check_idle_values("after reset");
        end
        game_won = 1'b0;

`ifdef GAME_HIGH_SCORE_EN
        check("high_score after reset", int'(high_score), 0);
        play_game(5);
        check("high_score game1", int'(high_score), 5);
        leave_over();
        check("high_score kept in idle", int'(high_score), 5);
        play_game(3);
        check("high_score game2", int'(high_score), 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
